// File: rtl/present_seq_ctrl.sv
// Sequencing controller for an iterative PRESENT-80 datapath: it loads two 32-bit input
// words, runs ROUNDS round cycles plus a final whitening, then hands out two output words.
module present_seq_ctrl #(
   parameter int ROUNDS = 31,
   parameter int CW     = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          din_valid,
   output logic          din_ready,
   input  logic          abort,
   input  logic          dout_ready,
   output logic          ld_hi,
   output logic          ld_lo,
   output logic          round_en,
   output logic [4:0]    round_cnt,
   output logic          final_xor,
   output logic          dout_sel,
   output logic          dout_valid,
   output logic          done1,
   output logic          done2,
   output logic          busy,
   output logic [3:0]    state,
   output logic [CW-1:0] blk_cnt
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LOAD_LO = 4'd1,
      ROUND   = 4'd2,
      FINAL   = 4'd3,
      OUT_HI  = 4'd4,
      OUT_LO  = 4'd5
   } state_t;

   localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

   state_t     state_q;
   state_t     state_d;
   logic [4:0] cnt_q;
   logic [4:0] cnt_d;
   logic       blk_inc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         blk_cnt <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (blk_inc) begin
            blk_cnt <= blk_cnt + CW'(1);
         end
      end
   end

   // abort overrides every transition; the round counter is nonzero only inside ROUND
   always_comb begin
      state_d = state_q;
      cnt_d   = 5'd0;
      blk_inc = 1'b0;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (din_valid) begin
                  state_d = LOAD_LO;
               end
            end
            LOAD_LO: begin
               if (din_valid) begin
                  state_d = ROUND;
                  cnt_d   = 5'd1;
               end
            end
            ROUND: begin
               if (cnt_q == LAST_ROUND) begin
                  state_d = FINAL;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
            FINAL: begin
               state_d = OUT_HI;
            end
            OUT_HI: begin
               if (dout_ready) begin
                  state_d = OUT_LO;
               end
            end
            OUT_LO: begin
               if (dout_ready) begin
                  state_d = IDLE;
                  blk_inc = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Datapath strobes decode straight from the state register so they cannot glitch
   always_comb begin
      round_en   = 1'b0;
      final_xor  = 1'b0;
      dout_sel   = 1'b0;
      dout_valid = 1'b0;
      done1      = 1'b0;
      done2      = 1'b0;
      case (state_q)
         ROUND:   round_en = 1'b1;
         FINAL:   final_xor = 1'b1;
         OUT_HI: begin
            dout_valid = 1'b1;
            done1      = 1'b1;
         end
         OUT_LO: begin
            dout_sel   = 1'b1;
            dout_valid = 1'b1;
            done2      = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign din_ready = !rst && ((state_q == IDLE) || (state_q == LOAD_LO));
   assign ld_hi     = din_valid && din_ready && !abort && (state_q == IDLE);
   assign ld_lo     = din_valid && din_ready && !abort && (state_q == LOAD_LO);
   assign round_cnt = cnt_q;
   assign state     = state_q;

endmodule

// File: tb/tb_present_seq_ctrl.sv
// Bench for present_seq_ctrl: block-level timeline model plus a PRESENT-80 datapath
// driven by the controller strobes, with a CW=2 twin instance for counter wrap.
module tb_present_seq_ctrl;

   localparam int ROUNDS = 31;

   logic        clk = 1'b0;
   logic        rst;
   logic        din_valid;
   logic        abort;
   logic        dout_ready;
   logic [31:0] din;

   logic        din_ready, ld_hi, ld_lo, round_en, final_xor;
   logic        dout_sel, dout_valid, done1, done2, busy;
   logic [4:0]  round_cnt;
   logic [3:0]  state;
   logic [15:0] blk_cnt;

   logic        w_din_ready, w_ld_hi, w_ld_lo, w_round_en, w_final_xor;
   logic        w_dout_sel, w_dout_valid, w_done1, w_done2, w_busy;
   logic [4:0]  w_round_cnt;
   logic [3:0]  w_state;
   logic [1:0]  w_blk_cnt;

   int nChecks = 0;
   int nErrors = 0;
   int modelBlk = 0;

   always #5 clk = ~clk;

   present_seq_ctrl #(.ROUNDS(ROUNDS), .CW(16)) dut (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready),
      .abort(abort), .dout_ready(dout_ready), .ld_hi(ld_hi), .ld_lo(ld_lo),
      .round_en(round_en), .round_cnt(round_cnt), .final_xor(final_xor),
      .dout_sel(dout_sel), .dout_valid(dout_valid), .done1(done1), .done2(done2),
      .busy(busy), .state(state), .blk_cnt(blk_cnt)
   );

   present_seq_ctrl #(.ROUNDS(ROUNDS), .CW(2)) dutWrap (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(w_din_ready),
      .abort(abort), .dout_ready(dout_ready), .ld_hi(w_ld_hi), .ld_lo(w_ld_lo),
      .round_en(w_round_en), .round_cnt(w_round_cnt), .final_xor(w_final_xor),
      .dout_sel(w_dout_sel), .dout_valid(w_dout_valid), .done1(w_done1), .done2(w_done2),
      .busy(w_busy), .state(w_state), .blk_cnt(w_blk_cnt)
   );

   // PRESENT-80 primitives for the bench-side datapath (key fixed at 0)
   function automatic logic [3:0] sb(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
         4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
         4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
         4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
      endcase
   endfunction

   function automatic logic [63:0] roundFn(input logic [63:0] s, input logic [79:0] k);
      logic [63:0] x;
      logic [63:0] y;
      x = s ^ k[79:16];
      for (int i = 0; i < 16; i++) x[i*4 +: 4] = sb(x[i*4 +: 4]);
      y = '0;
      for (int i = 0; i < 63; i++) y[(i * 16) % 63] = x[i];
      y[63] = x[63];
      return y;
   endfunction

   function automatic logic [79:0] keyUpd(input logic [79:0] k, input logic [4:0] rc);
      logic [79:0] t;
      t = {k[18:0], k[79:19]};
      t[79:76] = sb(t[79:76]);
      t[19:15] = t[19:15] ^ rc;
      return t;
   endfunction

   logic [63:0] dpState;
   logic [79:0] dpKey;
   logic [31:0] dout;

   always @(posedge clk) begin
      if (ld_hi) begin
         dpState[63:32] <= din;
         dpKey          <= '0;
      end
      if (ld_lo) dpState[31:0] <= din;
      if (round_en) begin
         dpState <= roundFn(dpState, dpKey);
         dpKey   <= keyUpd(dpKey, round_cnt);
      end
      if (final_xor) dpState <= dpState ^ dpKey[79:16];
   end

   assign dout = dout_sel ? dpState[31:0] : dpState[63:32];

   typedef struct {
      int          st;
      int          rc;
      bit          dv;
      bit          dr;
      logic [31:0] dw;
      bit          chk;
      logic [31:0] dexp;
   } cyc_t;

   // Expected control vector for one cycle from the documented per-state output table
   function automatic logic [18:0] expOut(input int st, input int rc, input bit dv, input bit ab);
      logic rdy;
      rdy = (st == 0) || (st == 1);
      return {4'(st), 5'(rc), rdy, dv && !ab && st == 0, dv && !ab && st == 1,
              st == 2, st == 3, st == 5, st == 4 || st == 5, st == 4, st == 5, st != 0};
   endfunction

   function automatic logic [18:0] obsVec();
      return {state, round_cnt, din_ready, ld_hi, ld_lo, round_en, final_xor,
              dout_sel, dout_valid, done1, done2, busy};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic applyStimulus(input cyc_t c, input bit ab);
      @(negedge clk);
      din_valid  = c.dv;
      din        = c.dw;
      abort      = ab;
      dout_ready = c.dr;
      #1;
      checkOutput("ctl", 32'(obsVec()), 32'(expOut(c.st, c.rc, c.dv, ab)));
      checkOutput("blk", 32'(blk_cnt), 32'(modelBlk % 65536));
      checkOutput("blkWrap", 32'(w_blk_cnt), 32'(modelBlk % 4));
      if (c.chk) checkOutput("dout", dout, c.dexp);
   endtask

   // Builds the cycle-by-cycle timeline of one block from the latency rules and plays it.
   // abortIdx: -1 none, -2 random; stopIdx >= 0 ends the block early without abort.
   task automatic runBlock(input logic [31:0] hi, input logic [31:0] lo,
                           input int idleGap, input int loadGap, input int s1, input int s2,
                           input int abortIdx, input int stopIdx, input bit chk,
                           input logic [31:0] eh, input logic [31:0] el);
      cyc_t q[$];
      cyc_t c;
      int   ai;
      c = '{0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
      for (int i = 0; i < idleGap; i++) begin
         c.st = 0; c.rc = 0; c.dv = 0; c.dr = 1'($urandom); c.dw = $urandom;
         q.push_back(c);
      end
      c.st = 0; c.dv = 1; c.dw = hi; c.dr = 1'($urandom); q.push_back(c);
      for (int i = 0; i < loadGap; i++) begin
         c.st = 1; c.dv = 0; c.dw = $urandom; c.dr = 1'($urandom); q.push_back(c);
      end
      c.st = 1; c.dv = 1; c.dw = lo; c.dr = 1'($urandom); q.push_back(c);
      for (int r = 1; r <= ROUNDS; r++) begin
         c.st = 2; c.rc = r; c.dv = ($urandom_range(0, 3) != 0); c.dw = $urandom;
         c.dr = 1'($urandom); q.push_back(c);
      end
      c.st = 3; c.rc = 0; c.dv = 1'($urandom); c.dr = 1'($urandom); q.push_back(c);
      for (int i = 0; i <= s1; i++) begin
         c.st = 4; c.dv = 1'($urandom); c.dr = (i == s1); c.chk = chk; c.dexp = eh;
         q.push_back(c);
      end
      for (int i = 0; i <= s2; i++) begin
         c.st = 5; c.dv = 1'($urandom); c.dr = (i == s2); c.chk = chk; c.dexp = el;
         q.push_back(c);
      end
      ai = (abortIdx == -2) ? int'($urandom_range(0, q.size() - 1)) : abortIdx;
      for (int i = 0; i < q.size(); i++) begin
         applyStimulus(q[i], i == ai);
         if (i == ai || i == stopIdx) return;
      end
      modelBlk++;
   endtask

   initial begin
      rst = 1'b1; din_valid = 1'b0; abort = 1'b0; dout_ready = 1'b0; din = '0;
      repeat (3) begin
         @(negedge clk);
         #1;
         checkOutput("rstCtl", 32'(obsVec()), 32'h0);
         checkOutput("rstBlk", 32'(blk_cnt), 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;

      runBlock(32'h0, 32'h0, 0, 0, 0, 0, -1, -1, 1'b1, 32'h5579C138, 32'h7B228445);
      runBlock(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 2, 0, 0, -1, -1, 1'b1, 32'hA112FFC7, 32'h2F68417B);
      runBlock(32'h0, 32'h0, 0, 0, 10, 2, -1, -1, 1'b1, 32'h5579C138, 32'h7B228445);
      runBlock(32'h0, 32'h0, 2, 1, 0, 0, 2 + 1 + 1 + 1 + 16, -1, 1'b0, 32'h0, 32'h0);
      runBlock(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 1, -1, -1, 1'b1, 32'hA112FFC7, 32'h2F68417B);

      for (int b = 0; b < 20; b++) begin
         runBlock($urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0) ? -2 : -1, -1, 1'b0, 32'h0, 32'h0);
      end

      // Reset pulsed in the first OUT_LO cycle, between clock edges
      runBlock($urandom, $urandom, 0, 0, 0, 0, -1, 35, 1'b0, 32'h0, 32'h0);
      din_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      checkOutput("asyncRstCtl", 32'(obsVec()), 32'h0);
      checkOutput("asyncRstBlk", 32'(blk_cnt), 32'h0);
      checkOutput("asyncRstWrap", 32'(w_blk_cnt), 32'h0);
      @(negedge clk);
      #1;
      checkOutput("rstHoldCtl", 32'(obsVec()), 32'h0);
      modelBlk = 0;
      rst = 1'b0;
      din_valid = 1'b0;

      runBlock(32'h0, 32'h0, 0, 0, 0, 0, -1, -1, 1'b1, 32'h5579C138, 32'h7B228445);
      for (int b = 0; b < 5; b++) begin
         runBlock($urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
                  $urandom_range(0, 2), $urandom_range(0, 2), -1, -1, 1'b0, 32'h0, 32'h0);
      end
      runBlock(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, -1, -1, 1'b1, 32'hA112FFC7, 32'h2F68417B);

      @(negedge clk);
      din_valid = 1'b0;
      abort = 1'b0;
      #1;
      checkOutput("endBlk", 32'(blk_cnt), 32'(modelBlk));
      checkOutput("endWrap", 32'(w_blk_cnt), 32'(modelBlk % 4));
      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule

// File: doc/present_seq_ctrl.md
PRESENT_SEQ_CTRL -- requirements
Module: present_seq_ctrl

Interface
REQ-001 The block SHALL take parameter ROUNDS, default 31, the number of PRESENT round-function cycles per block.
REQ-002 The block SHALL take parameter CW, default 16, the width of the completed-block counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 din_valid  input  1  a 32-bit input word is present on the datapath input.
REQ-006 din_ready  output  1  the controller accepts an input word this cycle.
REQ-007 abort  input  1  synchronous cancel of the block in flight.
REQ-008 dout_ready  input  1  the sink takes the current output word.
REQ-009 ld_hi  output  1  datapath loads the state bits [63:32] from din.
REQ-010 ld_lo  output  1  datapath loads the state bits [31:0] from din.
REQ-011 round_en  output  1  datapath applies one round (addRoundKey, sBox, pLayer) and updates the key schedule.
REQ-012 round_cnt  output  5  current round index fed to the key-schedule counter XOR.
REQ-013 final_xor  output  1  datapath applies the final whitening with K32.
REQ-014 dout_sel  output  1  0 selects state[63:32] onto dout, 1 selects state[31:0].
REQ-015 dout_valid  output  1  dout holds a valid output word.
REQ-016 done1  output  1  the high output word is valid.
REQ-017 done2  output  1  the low output word is valid.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 state  output  4  encoded FSM state for debug.
REQ-020 blk_cnt  output  CW  count of completed blocks.

Function
REQ-021 The FSM SHALL have these states and encodings: IDLE=0, LOAD_LO=1, ROUND=2, FINAL=3, OUT_HI=4, OUT_LO=5. Codes 6-15 SHALL go to IDLE on the next edge.
REQ-022 IDLE: din_ready=1. When din_valid=1, ld_hi=1 that cycle and the next state is LOAD_LO.
REQ-023 LOAD_LO: din_ready=1. When din_valid=1, ld_lo=1 that cycle, round_cnt loads 1 and the next state is ROUND. The FSM SHALL wait indefinitely otherwise.
REQ-024 ld_hi SHALL equal din_valid AND din_ready AND (state==IDLE); ld_lo follows the same rule with LOAD_LO. Both are combinational.
REQ-025 din_ready SHALL be 0 in ROUND, FINAL, OUT_HI and OUT_LO; din_valid SHALL be ignored in those states.
REQ-026 ROUND: round_en=1 every cycle and round_cnt increments each cycle. When round_cnt==ROUNDS, the next state is FINAL and round_cnt clears to 0.
REQ-027 FINAL: final_xor=1 for exactly one cycle, then the next state is OUT_HI.
REQ-028 Latency: if ld_lo fires at cycle T, round_en SHALL be high for T+1..T+ROUNDS with round_cnt=1..ROUNDS, final_xor SHALL be high at T+ROUNDS+1, and done1 SHALL first be high at T+ROUNDS+2.
REQ-029 OUT_HI: dout_sel=0, dout_valid=1, done1=1. The FSM SHALL hold until dout_ready=1, then go to OUT_LO.
REQ-030 OUT_LO: dout_sel=1, dout_valid=1, done2=1. On dout_ready=1, blk_cnt increments and the next state is IDLE.
REQ-031 blk_cnt SHALL wrap from 2^CW-1 to 0 with no flag.
REQ-032 round_en, final_xor, done1, done2, dout_valid and busy SHALL be Moore outputs, glitch-free from registered state.
REQ-033 abort=1 in any state SHALL force IDLE and round_cnt=0 on the next edge, with no blk_cnt increment.
REQ-034 When abort=1, ld_hi and ld_lo SHALL be 0 that cycle.
REQ-035 abort SHALL take priority over every other transition, including a dout_ready or din_valid in the same cycle.
REQ-036 round_cnt SHALL be 0 in IDLE, LOAD_LO, FINAL, OUT_HI and OUT_LO.

Reset
REQ-037 rst=1 SHALL immediately and asynchronously force state=IDLE, round_cnt=0 and blk_cnt=0, and force ld_hi, ld_lo, round_en, final_xor, dout_sel, dout_valid, done1, done2 and busy to 0. din_ready SHALL be 0 while rst=1.
REQ-038 Reset asserted mid-ROUND or mid-OUT SHALL discard the block. After release, the first accepted word SHALL be treated as a high word.

Verification
REQ-039 Nominal block: words 0x00000000, 0x00000000 back to back with dout_ready=1 -> ld_lo at T, 31 round_en cycles with round_cnt 1..31, final_xor at T+32, done1 at T+33, done2 at T+34, blk_cnt=1. With the PRESENT-80 datapath and key 0, dout reads 5579C138 then 7B228445.
REQ-040 Second block: plaintext FFFFFFFF_FFFFFFFF with key 0 -> dout reads A112FFC7 then 2F68417B, blk_cnt=2.
REQ-041 Output stall: dout_ready=0 for 10 cycles in OUT_HI -> done1 is held for 10 cycles, done2 never rises, and state stays 4.
REQ-042 Abort: abort=1 when round_cnt=17 -> state=0 and round_cnt=0 next cycle, blk_cnt unchanged; the next block completes normally.
REQ-043 Async reset: rst pulsed during OUT_LO -> all outputs are 0 before the next clock edge, blk_cnt=0; din_valid held during ROUND gives no ld_hi or ld_lo.
REQ-044 Wrap: with CW=2, complete 4 blocks -> blk_cnt reads 1, 2, 3, 0.
